// File: rtl/tetris_pkg.sv
// Shared PS/2 key constants, receiver state encoding and frame check helper.
// Imported by the PS/2 frame receiver and the keycode decoder.
package tetris_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Odd parity over data+parity and a high stop bit.
  function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_keycode_if.sv
// PS/2 line inputs and decoded key outputs of one keyboard port.
// slave = decoder side, master = keyboard/consumer side.
interface ps2_keycode_if;
  logic       i_ps2_clk;
  logic       i_ps2_dat;
  logic [7:0] o_key;
  logic       o_key_valid;
  logic       o_frame_err;

  modport master (
    output i_ps2_clk, i_ps2_dat,
    input  o_key, o_key_valid, o_frame_err
  );

  modport slave (
    input  i_ps2_clk, i_ps2_dat,
    output o_key, o_key_valid, o_frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx_frame.sv
// PS/2 frame receiver: sync + glitch filter + 11-bit frame FSM with inter-bit timeout.
// Strobes are combinational in the cycle the stop-bit event is seen; no backpressure.
module ps2_rx_frame
  import tetris_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_strobe,
  output logic       o_err_strobe
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]     clk_sync;
  logic [1:0]     dat_sync;
  logic           sclk;
  logic           sdat;
  logic           filt;
  logic           filt_d;
  logic [FCW-1:0] filt_cnt;
  logic           bit_evt;
  logic [TCW-1:0] to_cnt;
  logic           timeout;
  rx_state_t      state;
  rx_state_t      state_nxt;
  logic [7:0]     shreg;
  logic [2:0]     bit_cnt;
  logic           par;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], i_ps2_clk};
      dat_sync <= {dat_sync[0], i_ps2_dat};
    end
  end

  assign sclk = clk_sync[1];
  assign sdat = dat_sync[1];

  // Filtered clock follows the synchronized level only after FILTER_LEN stable cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (sclk == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt     <= sclk;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign bit_evt = filt_d & ~filt;
  assign timeout = (state != RX_IDLE) && !bit_evt && (to_cnt == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= '0;
    end else if (state == RX_IDLE || bit_evt) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:   if (bit_evt && !sdat) state_nxt = RX_DATA;
      RX_DATA:   if (timeout) state_nxt = RX_IDLE;
                 else if (bit_evt && bit_cnt == 3'd7) state_nxt = RX_PARITY;
      RX_PARITY: if (timeout) state_nxt = RX_IDLE;
                 else if (bit_evt) state_nxt = RX_STOP;
      RX_STOP:   if (timeout || bit_evt) state_nxt = RX_IDLE;
      default:   state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    o_byte_strobe = 1'b0;
    o_err_strobe  = timeout;
    if (state == RX_STOP && bit_evt) begin
      o_byte_strobe = frame_ok(shreg, par, sdat);
      o_err_strobe  = ~frame_ok(shreg, par, sdat);
    end
  end

  assign o_byte = shreg;

  // Partial bytes are dropped by clearing the shifter whenever the receiver is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          shreg   <= '0;
          bit_cnt <= '0;
        end
        RX_DATA: if (bit_evt) begin
          shreg   <= {sdat, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        RX_PARITY: if (bit_evt) par <= sdat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 keyboard keycode decoder: tracks the held key from make/break codes, E0 stripped.
// Outputs register 1 cycle after the stop-bit event; the keyboard cannot be stalled.
module ps2_keycode
  import tetris_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int FILTER_LEN  = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  ps2_keycode_if.slave  bus
);

  logic [7:0] rx_byte;
  logic       rx_stb;
  logic       rx_err;
  logic       is_ext;
  logic       is_brk;
  logic       is_key;
  logic       ext;
  logic       brk;
  logic [7:0] key_q;
  logic       vld_q;
  logic       err_q;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FILTER_LEN  (FILTER_LEN)
  ) u_rx (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ps2_clk     (bus.i_ps2_clk),
    .i_ps2_dat     (bus.i_ps2_dat),
    .o_byte        (rx_byte),
    .o_byte_strobe (rx_stb),
    .o_err_strobe  (rx_err)
  );

  assign is_ext = rx_stb && (rx_byte == PS2_EXT);
  assign is_brk = rx_stb && (rx_byte == PS2_BRK);
  assign is_key = rx_stb && !is_ext && !is_brk;

  // ext is tracked for completeness of the prefix state but never alters the key code.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_q <= 8'h00;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      ext   <= 1'b0;
      brk   <= 1'b0;
    end else begin
      vld_q <= is_key & ~brk;
      err_q <= rx_err;
      ext   <= (ext | is_ext) & ~(is_key | rx_err);
      brk   <= (brk | is_brk) & ~(is_key | rx_err);
      if (is_key) begin
        if (!brk) begin
          key_q <= rx_byte;
        end else if (rx_byte == key_q) begin
          key_q <= 8'h00;
        end
      end
    end
  end

  assign bus.o_key       = key_q;
  assign bus.o_key_valid = vld_q;
  assign bus.o_frame_err = err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: directed key sequences, errors, glitches, reset, then random frames.
module tb_ps2_keycode;
  import tetris_pkg::*;

  localparam int TO_CYC = 400;
  localparam int FLEN   = 4;
  localparam int HALF   = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_keycode_if bus();

  ps2_keycode #(.TIMEOUT_CYC(TO_CYC), .FILTER_LEN(FLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int last_valid_cyc = 0;
  int stop_cyc = 0;
  logic prev_vld = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] m_key = 8'h00;
  bit m_brk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_key_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (bus.o_frame_err) err_cnt++;
    if (bus.o_key_valid && bus.o_frame_err) both_cnt++;
    if ((bus.o_key_valid && prev_vld) || (bus.o_frame_err && prev_err)) wide_cnt++;
    prev_vld = bus.o_key_valid;
    prev_err = bus.o_frame_err;
  end

  // Reference decoder: last make wins, break clears only the matching key, errors clear prefixes.
  task automatic model_frame(input logic [7:0] b, input bit good, output int ev, output int ee);
    ev = 0;
    ee = good ? 0 : 1;
    if (!good) m_brk = 1'b0;
    else if (b == PS2_EXT) begin end
    else if (b == PS2_BRK) m_brk = 1'b1;
    else begin
      if (!m_brk) begin
        m_key = b;
        ev = 1;
      end else if (b == m_key) m_key = 8'h00;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    bus.i_ps2_dat = b;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      if (glitch && i == 9) bus.i_ps2_clk = 1'b0;
      if (glitch && i == 9 + FLEN - 2) bus.i_ps2_clk = 1'b1;
    end
    bus.i_ps2_clk = 1'b0;
    stop_cyc = cyc;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      if (glitch && i == 10) bus.i_ps2_clk = 1'b1;
      if (glitch && i == 10 + FLEN - 2) bus.i_ps2_clk = 1'b0;
    end
    bus.i_ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                            input bit glitch, input int nbits);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
    repeat (10) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit bad_par, input logic stop, input bit glitch,
                           output int dv, output int de, output int ev, output int ee);
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(b, bad_par, stop, glitch, 11);
    dv = valid_cnt - v0;
    de = err_cnt - e0;
    model_frame(b, !bad_par && (stop == 1'b1), ev, ee);
  endtask

  task automatic test_reset();
    bus.i_ps2_clk = 1'b1;
    bus.i_ps2_dat = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (bus.o_key !== 8'h00) begin n_fail++; $display("FAIL reset_key: got %h want 00", bus.o_key); end
    n_chk++; if (bus.o_key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_key_valid); end
    n_chk++; if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.o_frame_err); end
    rst_n = 1'b1;
    repeat (FLEN + 5) @(negedge clk);
  endtask

  task automatic test_make_break();
    int dv, de, ev, ee, lat, sv;
    run_frame(KEY_ENTER, 0, 1'b1, 0, dv, de, ev, ee);
    lat = last_valid_cyc - stop_cyc;
    n_chk++; if (bus.o_key !== 8'h5A) begin n_fail++; $display("FAIL make_key: got %h want 5a", bus.o_key); end
    n_chk++; if (dv !== 1 || de !== 0) begin n_fail++; $display("FAIL make_pulses: valid %0d err %0d want 1 0", dv, de); end
    n_chk++; if (lat < FLEN + 2 || lat > FLEN + 3) begin n_fail++; $display("FAIL make_latency: got %0d want %0d..%0d", lat, FLEN + 2, FLEN + 3); end
    run_frame(PS2_BRK, 0, 1'b1, 0, dv, de, ev, ee);
    sv = dv;
    run_frame(KEY_ENTER, 0, 1'b1, 0, dv, de, ev, ee);
    n_chk++; if (bus.o_key !== 8'h00) begin n_fail++; $display("FAIL break_key: got %h want 00", bus.o_key); end
    n_chk++; if (sv + dv !== 0) begin n_fail++; $display("FAIL break_valid: got %0d want 0", sv + dv); end
  endtask

  task automatic test_ext();
    int dv, de, ev, ee, tot;
    tot = 0;
    run_frame(PS2_EXT, 0, 1'b1, 0, dv, de, ev, ee); tot += dv;
    run_frame(KEY_UP, 0, 1'b1, 0, dv, de, ev, ee);  tot += dv;
    n_chk++; if (bus.o_key !== 8'h75) begin n_fail++; $display("FAIL ext_make_key: got %h want 75", bus.o_key); end
    run_frame(PS2_EXT, 0, 1'b1, 0, dv, de, ev, ee); tot += dv;
    run_frame(PS2_BRK, 0, 1'b1, 0, dv, de, ev, ee); tot += dv;
    run_frame(KEY_UP, 0, 1'b1, 0, dv, de, ev, ee);  tot += dv;
    n_chk++; if (bus.o_key !== 8'h00) begin n_fail++; $display("FAIL ext_break_key: got %h want 00", bus.o_key); end
    n_chk++; if (tot !== 1) begin n_fail++; $display("FAIL ext_valid_count: got %0d want 1", tot); end
  endtask

  task automatic test_last_wins();
    int dv, de, ev, ee, tot;
    tot = 0;
    run_frame(KEY_DOWN, 0, 1'b1, 0, dv, de, ev, ee); tot += dv;
    n_chk++; if (bus.o_key !== 8'h72) begin n_fail++; $display("FAIL lw_first: got %h want 72", bus.o_key); end
    run_frame(KEY_UP, 0, 1'b1, 0, dv, de, ev, ee); tot += dv;
    n_chk++; if (bus.o_key !== 8'h75) begin n_fail++; $display("FAIL lw_second: got %h want 75", bus.o_key); end
    run_frame(PS2_BRK, 0, 1'b1, 0, dv, de, ev, ee); tot += dv;
    run_frame(KEY_DOWN, 0, 1'b1, 0, dv, de, ev, ee); tot += dv;
    n_chk++; if (bus.o_key !== 8'h75) begin n_fail++; $display("FAIL lw_other_break: got %h want 75", bus.o_key); end
    n_chk++; if (tot !== 2) begin n_fail++; $display("FAIL lw_valid_count: got %0d want 2", tot); end
  endtask

  task automatic test_frame_errors();
    int dv, de, ev, ee;
    run_frame(KEY_ESC, 1, 1'b1, 0, dv, de, ev, ee);
    n_chk++; if (de !== 1 || dv !== 0) begin n_fail++; $display("FAIL parity_pulses: err %0d valid %0d want 1 0", de, dv); end
    n_chk++; if (bus.o_key !== 8'h75) begin n_fail++; $display("FAIL parity_key: got %h want 75", bus.o_key); end
    run_frame(KEY_ESC, 0, 1'b1, 0, dv, de, ev, ee);
    n_chk++; if (bus.o_key !== 8'h76 || dv !== 1) begin n_fail++; $display("FAIL parity_recover: key %h valid %0d want 76 1", bus.o_key, dv); end
    run_frame(KEY_DOWN, 0, 1'b0, 0, dv, de, ev, ee);
    n_chk++; if (de !== 1 || bus.o_key !== 8'h76) begin n_fail++; $display("FAIL stop_err: err %0d key %h want 1 76", de, bus.o_key); end
    run_frame(PS2_BRK, 0, 1'b1, 0, dv, de, ev, ee);
    run_frame(8'h00, 1, 1'b1, 0, dv, de, ev, ee);
    run_frame(KEY_RIGHT, 0, 1'b1, 0, dv, de, ev, ee);
    n_chk++; if (bus.o_key !== 8'h74 || dv !== 1) begin n_fail++; $display("FAIL err_clears_brk: key %h valid %0d want 74 1", bus.o_key, dv); end
  endtask

  task automatic test_timeout();
    int dv, de, ev, ee, e0, v0;
    e0 = err_cnt;
    v0 = valid_cnt;
    send_frame(KEY_ENTER, 0, 1'b1, 0, 5);
    repeat (TO_CYC - 60) @(negedge clk);
    n_chk++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d want 0", err_cnt - e0); end
    repeat (100) @(negedge clk);
    n_chk++; if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL timeout_err: err %0d valid %0d want 1 0", err_cnt - e0, valid_cnt - v0); end
    model_frame(8'h00, 0, ev, ee);
    run_frame(KEY_ENTER, 0, 1'b1, 0, dv, de, ev, ee);
    n_chk++; if (bus.o_key !== 8'h5A || dv !== 1 || de !== 0) begin n_fail++; $display("FAIL timeout_recover: key %h valid %0d err %0d want 5a 1 0", bus.o_key, dv, de); end
  endtask

  task automatic test_glitch();
    int dv, de, ev, ee;
    run_frame(KEY_LEFT, 0, 1'b1, 1, dv, de, ev, ee);
    n_chk++; if (bus.o_key !== 8'h6B || dv !== 1 || de !== 0) begin n_fail++; $display("FAIL glitch_frame: key %h valid %0d err %0d want 6b 1 0", bus.o_key, dv, de); end
  endtask

  task automatic test_reset_mid_frame();
    int dv, de, ev, ee, v0, e0;
    send_frame(8'hFC, 0, 1'b1, 0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.o_key !== 8'h00 || bus.o_key_valid !== 1'b0 || bus.o_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: key %h valid %b err %b want 00 0 0", bus.o_key, bus.o_key_valid, bus.o_frame_err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_key = 8'h00;
    m_brk = 1'b0;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    repeat (10) @(negedge clk);
    n_chk++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0 || bus.o_key !== 8'h00) begin
      n_fail++; $display("FAIL midreset_remainder: valid %0d err %0d key %h want 0 0 00", valid_cnt - v0, err_cnt - e0, bus.o_key);
    end
    run_frame(KEY_DOWN, 0, 1'b1, 0, dv, de, ev, ee);
    n_chk++; if (bus.o_key !== 8'h72 || dv !== 1) begin n_fail++; $display("FAIL midreset_recover: key %h valid %0d want 72 1", bus.o_key, dv); end
  endtask

  task automatic test_random();
    logic [7:0] tbl [8];
    logic [7:0] b;
    bit bad;
    int dv, de, ev, ee;
    tbl = '{PS2_EXT, PS2_BRK, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_ENTER, KEY_ESC};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = tbl[$urandom_range(0, 7)];
      bad = ($urandom_range(0, 9) == 0);
      run_frame(b, bad, 1'b1, 0, dv, de, ev, ee);
      n_chk++; if (bus.o_key !== m_key) begin n_fail++; $display("FAIL rand_key[%0d]: byte %h got %h want %h", n, b, bus.o_key, m_key); end
      n_chk++; if (dv !== ev) begin n_fail++; $display("FAIL rand_valid[%0d]: byte %h got %0d want %0d", n, b, dv, ev); end
      n_chk++; if (de !== ee) begin n_fail++; $display("FAIL rand_err[%0d]: byte %h got %0d want %0d", n, b, de, ee); end
    end
    n_chk++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d want 0", both_cnt); end
    n_chk++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d want 0", wide_cnt); end
  endtask

  initial begin
    bus.i_ps2_clk = 1'b1;
    bus.i_ps2_dat = 1'b1;
    test_reset();
    test_make_break();
    test_ext();
    test_last_wins();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keycode.md
PS2_KEYCODE -- requirements
Module: ps2_keycode

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100000, max i_clk cycles between PS/2 falling edges inside a frame before the frame is abandoned.
REQ-002 Parameter FILTER_LEN, default 8, i_clk cycles a synchronized PS/2 clock level must hold before it is accepted.
REQ-003 i_clk  input  1  system clock; one clock; all state on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-006 i_ps2_dat  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-007 o_key  output  8  scan code of the currently held key; 8'h00 when none held; E0 prefix stripped.
REQ-008 o_key_valid  output  1  one-cycle pulse on every accepted make code, including typematic repeats.
REQ-009 o_frame_err  output  1  one-cycle pulse on a frame with parity or stop-bit error, or a timeout.

Function
REQ-010 i_ps2_clk and i_ps2_dat SHALL each pass through a 2-flop synchronizer before any use.
REQ-011 The filtered PS/2 clock SHALL change only after the synchronized level is stable for FILTER_LEN consecutive cycles; a falling edge of the filtered clock is a "bit event".
REQ-012 Frame receiver states: RX_IDLE, RX_DATA, RX_PARITY, RX_STOP; data sampled at each bit event.
REQ-013 RX_IDLE -> RX_DATA on a bit event with data 0 (start bit); data 1 in RX_IDLE is ignored.
REQ-014 RX_DATA shifts 8 bits LSB first, then RX_PARITY, then RX_STOP, then RX_IDLE.
REQ-015 A byte is accepted only if data byte plus parity bit has odd parity and the stop bit is 1; otherwise o_frame_err pulses and the byte is discarded.
REQ-016 Outside RX_IDLE, TIMEOUT_CYC cycles without a bit event SHALL return to RX_IDLE, pulse o_frame_err, and discard partial data.
REQ-017 Decoder flags ext (after 8'hE0) and brk (after 8'hF0) SHALL be set by those bytes and cleared after the next non-prefix byte.
REQ-018 Any frame error SHALL clear ext and brk.
REQ-019 Non-prefix byte with brk=0 (make): o_key <= byte and o_key_valid pulses, whether or not another key is held (last pressed wins).
REQ-020 Non-prefix byte with brk=1 (break): o_key <= 8'h00 only if byte equals o_key; otherwise o_key is unchanged; o_key_valid stays 0.
REQ-021 The ext flag SHALL NOT affect o_key (E0 75 and 75 both give 8'h75).
REQ-022 o_key, o_key_valid and o_frame_err update exactly 1 cycle after the cycle in which the stop-bit event is detected.
REQ-023 o_key_valid and o_frame_err SHALL never be high in the same cycle.

Reset
REQ-024 Reset assertion, including mid-frame, SHALL immediately set o_key=8'h00, o_key_valid=0, o_frame_err=0, receiver RX_IDLE, and clear ext, brk, shift register, timeout counter and filter state (filtered clock = 1).
REQ-025 After reset deassertion, a frame already in progress SHALL be dropped, because the receiver waits for a start bit from RX_IDLE.

Structure
REQ-026 Shared package tetris_pkg SHALL hold the key constants KEY_UP 8'h75, KEY_DOWN 8'h72, KEY_LEFT 8'h6B, KEY_RIGHT 8'h74, KEY_ENTER 8'h5A, KEY_ESC 8'h76, PS2_EXT 8'hE0, PS2_BRK 8'hF0, and the receiver state enum.
REQ-027 Sub-module ps2_rx_frame SHALL contain the synchronizer, filter, frame FSM and timeout, and output byte, byte_strobe and err_strobe; ps2_keycode SHALL contain the make/break decoding.
REQ-028 Each player's keyboard gets its own ps2_keycode instance.

Verification
REQ-029 Frame 5A (parity 1, stop 1) -> o_key=8'h5A and one o_key_valid pulse 1 cycle after the stop event; then frames F0 5A -> o_key=8'h00 with no valid pulse.
REQ-030 Frames E0 75, then E0 F0 75 -> o_key=8'h75 then 8'h00; one valid pulse total.
REQ-031 Frames 72, 75, F0 72 -> o_key 8'h72, then 8'h75, and remains 8'h75 after the break of 72; two valid pulses.
REQ-032 Frame 76 with wrong parity bit -> one o_frame_err pulse; o_key unchanged; the next good frame 76 is accepted.
REQ-033 Stop clocking after 4 data bits for more than TIMEOUT_CYC cycles -> one o_frame_err pulse; a following full frame 5A decodes correctly.
REQ-034 Glitch pulses on i_ps2_clk shorter than FILTER_LEN cycles during a frame -> no extra bits, byte correct; assert i_rst_n=0 mid-frame -> all outputs 0 at once and the remainder of the frame is ignored.
